// File: rtl/game_select_ctrl_if.sv
// Bundle between the button/enable sources and the game-select controller:
// pulse and enable inputs toward the controller, selection, grants and display override back.
interface game_select_ctrl_if #(
  parameter int NUM_GAMES = 3
);
  logic                 switch_pulse;
  logic                 btn1_pulse;
  logic                 btn2_pulse;
  logic [NUM_GAMES-1:0] game_enable;
  logic [1:0]           game_sel;
  logic [NUM_GAMES-1:0] btn1_grant;
  logic [NUM_GAMES-1:0] btn2_grant;
  logic                 disp_override;
  logic [3:0]           disp_value;
  logic                 busy;

  modport master (
    output switch_pulse, btn1_pulse, btn2_pulse, game_enable,
    input  game_sel, btn1_grant, btn2_grant, disp_override, disp_value, busy
  );

  modport slave (
    input  switch_pulse, btn1_pulse, btn2_pulse, game_enable,
    output game_sel, btn1_grant, btn2_grant, disp_override, disp_value, busy
  );
endinterface

// File: rtl/game_select_ctrl.sv
// Game-select sequencer: picks the next enabled game, blanks the display, shows the
// new game number, then routes button pulses to the active game only.
module game_select_ctrl #(
  parameter int NUM_GAMES    = 3,
  parameter int BLANK_CYCLES = 4,
  parameter int SHOW_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  game_select_ctrl_if.slave  bus
);

  localparam int MAX_CYCLES = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES);
  localparam logic [3:0]       BLANK_CODE = 4'd12;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cur_en;
  logic             any_en;
  logic             start_switch;
  logic             grant_ok;
  logic [1:0]       next_sel;
  logic             disp_override;
  logic [3:0]       disp_value;
  logic             busy;
  logic [NUM_GAMES-1:0] btn1_grant;
  logic [NUM_GAMES-1:0] btn2_grant;

  // Enable bit at a runtime index, expressed with constant bit selects only.
  function automatic logic enabled_at(input logic [NUM_GAMES-1:0] mask, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int j = 0; j < NUM_GAMES; j++) begin
      if (idx == 3'(j)) r = mask[j];
    end
    return r;
  endfunction

  assign any_en = |bus.game_enable;

  always_comb begin
    cur_en = enabled_at(bus.game_enable, {1'b0, sel_q});
  end

  // Scan sel+1, sel+2, ... modulo NUM_GAMES; the last candidate is sel itself.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    next_sel = sel_q;
    found    = 1'b0;
    for (int k = 1; k <= NUM_GAMES; k++) begin
      idx = {1'b0, sel_q} + 3'(k);
      if (idx >= 3'(NUM_GAMES)) idx = idx - 3'(NUM_GAMES);
      if (!found && enabled_at(bus.game_enable, idx)) begin
        next_sel = idx[1:0];
        found    = 1'b1;
      end
    end
  end

  // A disabled current game triggers the same transition as an explicit switch.
  assign start_switch = (state_q == PLAY) && any_en && (bus.switch_pulse || !cur_en);
  assign grant_ok     = (state_q == PLAY) && cur_en && !bus.switch_pulse;

  always_comb begin
    btn1_grant = '0;
    btn2_grant = '0;
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (grant_ok && (sel_q == 2'(i))) begin
        btn1_grant[i] = bus.btn1_pulse;
        btn2_grant[i] = bus.btn2_pulse;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    disp_override = 1'b0;
    disp_value    = 4'd0;
    busy          = 1'b0;

    case (state_q)
      PLAY: begin
        if (start_switch) begin
          sel_d   = next_sel;
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end
      end

      BLANK: begin
        disp_override = 1'b1;
        disp_value    = BLANK_CODE;
        busy          = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = SHOW;
          cnt_d   = SHOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SHOW: begin
        disp_override = 1'b1;
        disp_value    = {2'b00, sel_q} + 4'd1;
        busy          = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = PLAY;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; reset is synchronous and overrides any transition in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PLAY;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.game_sel      = sel_q;
  assign bus.btn1_grant    = btn1_grant;
  assign bus.btn2_grant    = btn2_grant;
  assign bus.disp_override = disp_override;
  assign bus.disp_value    = disp_value;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Bench for game_select_ctrl: directed scenarios plus random traffic, every cycle
// compared against a timestamp-based model of the transition sequence.
module tb_game_select_ctrl;

  localparam int NG = 3;
  localparam int B  = 4;
  localparam int S  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  game_select_ctrl_if #(.NUM_GAMES(NG)) bus ();

  game_select_ctrl #(
    .NUM_GAMES    (NG),
    .BLANK_CYCLES (B),
    .SHOW_CYCLES  (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: cycle index, selected game, first PLAY cycle after the current transition.
  int cyc     = 0;
  int m_sel   = 0;
  int m_end   = 0;
  bit m_known = 1'b0;

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, actual, expected);
    end
  endtask

  function automatic int next_game(input int sel, input int en);
    for (int k = 1; k <= NG; k++) begin
      int idx;
      idx = (sel + k) % NG;
      if (((en >> idx) & 1) != 0) return idx;
    end
    return sel;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance.
  task automatic run(input bit sw, input bit b1, input bit b2,
                     input logic [NG-1:0] en, input bit rst);
    bit in_play;
    bit cur_en;
    int exp_g1, exp_g2, exp_val;

    rst_n            = rst;
    bus.switch_pulse = sw;
    bus.btn1_pulse   = b1;
    bus.btn2_pulse   = b2;
    bus.game_enable  = en;
    #2;

    in_play = (cyc >= m_end);
    cur_en  = ((int'(en) >> m_sel) & 1) != 0;
    exp_g1  = (in_play && cur_en && !sw && b1) ? (1 << m_sel) : 0;
    exp_g2  = (in_play && cur_en && !sw && b2) ? (1 << m_sel) : 0;
    if (in_play)                exp_val = 0;
    else if (cyc < m_end - S)   exp_val = 12;
    else                        exp_val = m_sel + 1;

    if (m_known) begin
      check("game_sel",      int'(bus.game_sel),      m_sel);
      check("btn1_grant",    int'(bus.btn1_grant),    exp_g1);
      check("btn2_grant",    int'(bus.btn2_grant),    exp_g2);
      check("disp_override", int'(bus.disp_override), in_play ? 0 : 1);
      check("disp_value",    int'(bus.disp_value),    exp_val);
      check("busy",          int'(bus.busy),          in_play ? 0 : 1);
    end

    @(posedge clk);
    if (!rst) begin
      m_sel   = 0;
      m_end   = cyc + 1;
      m_known = 1'b1;
    end else if (in_play && en != '0 && (sw || !cur_en)) begin
      m_sel = next_game(m_sel, int'(en));
      m_end = cyc + 1 + B + S;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [NG-1:0] en);
    for (int i = 0; i < n; i++) run(1'b0, 1'b0, 1'b0, en, 1'b1);
  endtask

  initial begin
    logic [NG-1:0] en;
    bit sw, b1, b2, rst;

    // Reset, then a button pulse routed straight to game 0.
    run(0, 0, 0, 3'b111, 0);
    run(0, 0, 0, 3'b111, 0);
    run(0, 1, 0, 3'b111, 1);
    idle(2, 3'b111);

    // Full transition 0 -> 1 with buttons inside and just after it.
    for (int i = 0; i <= 13; i++) run(i == 0, (i == 6) || (i == 13), 1'b0, 3'b111, 1'b1);
    check("sel_after_first_switch", int'(bus.game_sel), 1);

    // Mask 101: game 1 is skipped in both directions.
    run(0, 0, 0, 3'b101, 0);
    run(1, 0, 0, 3'b101, 1);
    idle(12, 3'b101);
    check("skip_to_game2", int'(bus.game_sel), 2);
    run(1, 0, 0, 3'b101, 1);
    idle(12, 3'b101);
    check("wrap_to_game0", int'(bus.game_sel), 0);

    // Only game 0 enabled: selection stays, transition still runs.
    run(1, 0, 0, 3'b001, 1);
    check("busy_single_game", int'(bus.busy), 1);
    idle(11, 3'b001);
    run(0, 1, 0, 3'b001, 1);

    // Switch and button in one PLAY cycle, second switch during SHOW ignored.
    for (int i = 0; i <= 13; i++) run((i == 0) || (i == 7), 1'b0, (i == 0) || (i == 13), 3'b111, 1'b1);
    check("sel_after_ignored_switch", int'(bus.game_sel), 1);

    // Current game disabled: automatic switch to game 2.
    run(0, 1, 1, 3'b101, 1);
    check("auto_switch_sel", int'(bus.game_sel), 2);
    idle(12, 3'b101);

    // Empty mask: grants blocked and switch ignored.
    for (int i = 0; i < 4; i++) run(i[0], 1'b1, 1'b1, 3'b000, 1'b1);
    check("held_with_empty_mask", int'(bus.game_sel), 2);

    // Reset in the middle of BLANK.
    run(1, 0, 0, 3'b111, 1);
    run(0, 0, 0, 3'b111, 1);
    run(0, 0, 0, 3'b111, 0);
    check("reset_mid_blank_busy", int'(bus.busy), 0);
    check("reset_mid_blank_sel",  int'(bus.game_sel), 0);
    idle(3, 3'b111);

    // Random traffic including mask changes during transitions and rare resets.
    en = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(24) == 0) en = NG'($urandom_range(7));
      sw  = ($urandom_range(9) == 0);
      b1  = ($urandom_range(2) == 0);
      b2  = ($urandom_range(2) == 0);
      rst = ($urandom_range(299) != 0);
      run(sw, b1, b2, en, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
